// File: rtl/lpc_analyzer_pkg.sv
// Shared defaults, FSM state encodings and output saturation for the LPC analyzer.
package lpc_analyzer_pkg;

    localparam int unsigned ORDER_DEF = 10;
    localparam int unsigned MAXN_DEF  = 256;
    localparam int unsigned ACCW_DEF  = 40;
    localparam int unsigned SHIFT_DEF = 8;

    typedef enum logic {
        IDLE,
        RUN
    } cap_state_t;

    typedef enum logic [1:0] {
        CIDLE,
        MAC,
        EMIT,
        DONE
    } cmp_state_t;

    function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
        if (v > 64'sh0000_0000_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (v < 64'shFFFF_FFFF_8000_0000)
            return 32'sh8000_0000;
        else
            return v[31:0];
    endfunction

endpackage

// File: rtl/lpc_mac.sv
// Multiply-accumulate: registered 16x16 product stage followed by an accumulator stage.
module lpc_mac #(
    parameter int unsigned ACCW = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [15:0]     a,
    input  logic signed [15:0]     b,
    output logic signed [ACCW-1:0] acc,
    output logic signed [ACCW-1:0] acc_nxt
);

    logic signed [31:0] prod;
    logic               prod_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod   <= 32'(a) * 32'(b);
            prod_v <= en;
            acc    <= clr ? '0 : acc_nxt;
        end
    end

    // Exposed so the caller can capture the final sum in the same cycle it forms.
    assign acc_nxt = prod_v ? acc + ACCW'(prod) : acc;

endmodule

// File: rtl/lpc_analyzer.sv
// LPC front end: double-buffered frame capture with zero-crossing count, then
// per-lag autocorrelation streamed out with valid/ready and a voicing decision.
module lpc_analyzer
    import lpc_analyzer_pkg::*;
#(
    parameter int unsigned ORDER = ORDER_DEF,
    parameter int unsigned MAXN  = MAXN_DEF,
    parameter int unsigned ACCW  = ACCW_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               v,
    input  logic signed [15:0] x,
    input  logic [15:0]        framelen,
    input  logic [15:0]        zcr_thresh,
    input  logic [31:0]        energy_thresh,
    output logic signed [31:0] rout,
    output logic [3:0]         ridx,
    output logic               rvalid,
    input  logic               rready,
    output logic               voiced,
    output logic [15:0]        zcr,
    output logic               frame_done,
    output logic               overrun
);

    localparam int unsigned CW = $clog2(MAXN + 1);
    localparam int unsigned AW = $clog2(2 * MAXN);

    logic signed [15:0] mem [2*MAXN];

    cap_state_t    cap_st;
    logic          wbank;
    logic [CW-1:0] nlen;
    logic [CW-1:0] wptr;
    logic [15:0]   zcnt;
    logic          prev_sign;
    logic          hand;
    logic          hbank;
    logic [CW-1:0] hlen;
    logic [15:0]   hzcr;

    cmp_state_t         cmp_st;
    logic               cbank;
    logic [CW-1:0]      clen;
    logic [15:0]        czcr;
    logic [3:0]         k;
    logic [CW-1:0]      n;
    logic               issuing;
    logic               first;
    logic signed [31:0] r0;

    logic [CW-1:0]         n_clamp;
    logic                  busy;
    logic                  last_sample;
    logic                  zc;
    logic [15:0]           zcnt_nxt;
    logic [AW-1:0]         waddr;
    logic [AW-1:0]         rbase;
    logic signed [15:0]    mac_a;
    logic signed [15:0]    mac_b;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] acc_nxt;
    logic signed [31:0]    rsat;

    always_comb begin
        if ({16'd0, framelen} < ORDER + 1)
            n_clamp = CW'(ORDER + 1);
        else if ({16'd0, framelen} > MAXN)
            n_clamp = CW'(MAXN);
        else
            n_clamp = CW'(framelen);
    end

    // hand counts as busy so a hand-off is never issued while the last one is in flight.
    assign busy        = (cmp_st != CIDLE) || hand;
    assign last_sample = (wptr == nlen - 1'b1);
    assign zc          = (wptr != '0) && (x[15] != prev_sign);
    assign zcnt_nxt    = zcnt + 16'(zc);
    assign waddr       = (wbank ? AW'(MAXN) : AW'(0)) + AW'(wptr);
    assign rbase       = cbank ? AW'(MAXN) : AW'(0);
    assign mac_a       = mem[rbase + AW'(n)];
    assign mac_b       = mem[rbase + AW'(n) - AW'(k)];
    assign rsat        = sat32(64'(acc_nxt >>> SHIFT));

    always_ff @(posedge clk) begin
        if (cap_st == RUN && !stop && v)
            mem[waddr] <= x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_st    <= IDLE;
            wbank     <= 1'b0;
            nlen      <= '0;
            wptr      <= '0;
            zcnt      <= '0;
            prev_sign <= 1'b0;
            hand      <= 1'b0;
            hbank     <= 1'b0;
            hlen      <= '0;
            hzcr      <= '0;
            overrun   <= 1'b0;
        end else begin
            hand    <= 1'b0;
            overrun <= 1'b0;
            case (cap_st)
                IDLE: begin
                    if (start) begin
                        cap_st <= RUN;
                        nlen   <= n_clamp;
                        wptr   <= '0;
                        zcnt   <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        cap_st <= IDLE;
                    end else if (v) begin
                        prev_sign <= x[15];
                        if (last_sample) begin
                            wptr <= '0;
                            zcnt <= '0;
                            if (busy) begin
                                overrun <= 1'b1;
                            end else begin
                                hand  <= 1'b1;
                                hbank <= wbank;
                                hlen  <= nlen;
                                hzcr  <= zcnt_nxt;
                                wbank <= ~wbank;
                            end
                        end else begin
                            wptr <= wptr + 1'b1;
                            zcnt <= zcnt_nxt;
                        end
                    end
                end
            endcase
        end
    end

    lpc_mac #(.ACCW(ACCW)) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (first),
        .en      (issuing),
        .a       (mac_a),
        .b       (mac_b),
        .acc     (acc),
        .acc_nxt (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_st     <= CIDLE;
            cbank      <= 1'b0;
            clen       <= '0;
            czcr       <= '0;
            k          <= '0;
            n          <= '0;
            issuing    <= 1'b0;
            first      <= 1'b0;
            r0         <= '0;
            rout       <= '0;
            ridx       <= '0;
            rvalid     <= 1'b0;
            voiced     <= 1'b0;
            zcr        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (cmp_st)
                CIDLE: begin
                    if (hand) begin
                        cmp_st  <= MAC;
                        cbank   <= hbank;
                        clen    <= hlen;
                        czcr    <= hzcr;
                        k       <= '0;
                        n       <= '0;
                        issuing <= 1'b1;
                        first   <= 1'b1;
                    end
                end
                MAC: begin
                    first <= 1'b0;
                    if (issuing) begin
                        if (n == clen - 1'b1)
                            issuing <= 1'b0;
                        else
                            n <= n + 1'b1;
                    end else begin
                        // Last product sits in the accumulate stage; acc_nxt is the full sum.
                        cmp_st <= EMIT;
                        rvalid <= 1'b1;
                        ridx   <= k;
                        rout   <= rsat;
                        if (k == '0)
                            r0 <= rsat;
                    end
                end
                EMIT: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        if (k == 4'(ORDER)) begin
                            cmp_st     <= DONE;
                            frame_done <= 1'b1;
                            zcr        <= czcr;
                            voiced     <= (czcr < zcr_thresh) && (r0 >= $signed(energy_thresh));
                        end else begin
                            cmp_st  <= MAC;
                            k       <= k + 1'b1;
                            n       <= CW'(k) + 1'b1;
                            issuing <= 1'b1;
                            first   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    cmp_st <= CIDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_analyzer.sv
// Directed bench for lpc_analyzer: DC, alternating, saturation, backpressure,
// reset-in-flight and partial-frame cases with hand-computed expectations.
module tb_lpc_analyzer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, stop, v, rready;
    logic signed [15:0] x;
    logic [15:0]        framelen, zcr_thresh;
    logic [31:0]        energy_thresh;

    logic signed [31:0] rout, s0_rout;
    logic [3:0]         ridx, s0_ridx;
    logic               rvalid, s0_rvalid;
    logic               voiced, s0_voiced;
    logic [15:0]        zcr, s0_zcr;
    logic               frame_done, s0_frame_done;
    logic               overrun, s0_overrun;

    lpc_analyzer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .v(v), .x(x),
        .framelen(framelen), .zcr_thresh(zcr_thresh), .energy_thresh(energy_thresh),
        .rout(rout), .ridx(ridx), .rvalid(rvalid), .rready(rready),
        .voiced(voiced), .zcr(zcr), .frame_done(frame_done), .overrun(overrun)
    );

    lpc_analyzer #(.SHIFT(0)) dut_s0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .v(v), .x(x),
        .framelen(framelen), .zcr_thresh(zcr_thresh), .energy_thresh(energy_thresh),
        .rout(s0_rout), .ridx(s0_ridx), .rvalid(s0_rvalid), .rready(rready),
        .voiced(s0_voiced), .zcr(s0_zcr), .frame_done(s0_frame_done), .overrun(s0_overrun)
    );

    logic               use_s0 = 1'b0;
    logic signed [31:0] o_rout;
    logic [3:0]         o_ridx;
    logic               o_rvalid, o_voiced, o_frame_done;
    logic [15:0]        o_zcr;
    assign o_rout       = use_s0 ? s0_rout       : rout;
    assign o_ridx       = use_s0 ? s0_ridx       : ridx;
    assign o_rvalid     = use_s0 ? s0_rvalid     : rvalid;
    assign o_voiced     = use_s0 ? s0_voiced     : voiced;
    assign o_zcr        = use_s0 ? s0_zcr        : zcr;
    assign o_frame_done = use_s0 ? s0_frame_done : frame_done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_emit;
    bit          seq_ok;
    bit          timed_out;
    logic [31:0] got [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
                     tag, obs, $signed(obs), exp, $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, " rout"},       rout,       32'd0);
        chk({pfx, " ridx"},       ridx,       32'd0);
        chk({pfx, " rvalid"},     rvalid,     32'd0);
        chk({pfx, " voiced"},     voiced,     32'd0);
        chk({pfx, " zcr"},        zcr,        32'd0);
        chk({pfx, " frame_done"}, frame_done, 32'd0);
        chk({pfx, " overrun"},    overrun,    32'd0);
    endtask

    task automatic send_frame(input logic [15:0] flen, input int nsamp, input bit alt,
                              input int amp, input bit do_stop);
        framelen = flen;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < nsamp; i++) begin
            v = 1'b1;
            x = (alt && (i % 2 == 1)) ? 16'(-amp) : 16'(amp);
            step();
        end
        v = 1'b0;
        x = '0;
        if (do_stop) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
    endtask

    // Value is recorded before the edge that accepts it, so a lag already pending is not missed.
    task automatic collect(input int budget);
        bit fd;
        fd     = 1'b0;
        n_emit = 0;
        seq_ok = 1'b1;
        for (int i = 0; i < 16; i++) got[i] = 32'hDEAD_BEEF;
        rready = 1'b1;
        for (int t = 0; t < budget && !fd; t++) begin
            if (o_rvalid) begin
                if (o_ridx != n_emit[3:0]) seq_ok = 1'b0;
                if (n_emit < 16) got[n_emit] = o_rout;
                n_emit++;
            end
            if (o_frame_done) fd = 1'b1;
            else step();
        end
        timed_out = !fd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int held, unstable, ovr, cnt_v, cnt_fd, cnt_ov, t;
        logic [31:0] first_r;

        rst = 1'b1; start = 1'b0; stop = 1'b0; v = 1'b0; x = '0; rready = 1'b0;
        framelen = 16'd16; zcr_thresh = 16'd4; energy_thresh = 32'd100;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // DC frame, N=16, x=100
        send_frame(16'd16, 16, 1'b0, 100, 1'b1);
        collect(400);
        chk("dc done", timed_out, 0);
        chk("dc count", n_emit, 11);
        chk("dc order", seq_ok, 1);
        chk("dc lag0", got[0], 625);
        chk("dc lag1", got[1], 585);
        chk("dc lag10", got[10], 234);
        chk("dc zcr", o_zcr, 0);
        chk("dc voiced", o_voiced, 1);

        // framelen 0 clamps to ORDER+1 = 11
        send_frame(16'd0, 11, 1'b0, 100, 1'b1);
        collect(400);
        chk("clamp11 count", n_emit, 11);
        chk("clamp11 lag0", got[0], 429);
        chk("clamp11 lag10", got[10], 39);

        // Alternating +/-1000, N=32
        zcr_thresh = 16'd10;
        send_frame(16'd32, 32, 1'b1, 1000, 1'b1);
        collect(800);
        chk("alt done", timed_out, 0);
        chk("alt lag0", got[0], 125000);
        chk("alt lag1", got[1], -121094);
        chk("alt lag2", got[2], 117187);
        chk("alt zcr", o_zcr, 31);
        chk("alt voiced", o_voiced, 0);
        repeat (20) step();
        chk("alt zcr hold", zcr, 31);

        // Saturation on the SHIFT=0 instance; framelen 1000 clamps to 256
        use_s0 = 1'b1;
        send_frame(16'd1000, 256, 1'b0, 32767, 1'b1);
        collect(4000);
        chk("sat done", timed_out, 0);
        chk("sat count", n_emit, 11);
        chk("sat lag0", got[0], 32'h7FFF_FFFF);
        send_frame(16'd1000, 256, 1'b1, 32767, 1'b1);
        collect(4000);
        chk("satneg lag0", got[0], 32'h7FFF_FFFF);
        chk("satneg lag1", got[1], 32'h8000_0000);
        chk("satneg zcr", o_zcr, 255);
        use_s0 = 1'b0;

        // Backpressure: rready low, continuous samples, five frames' worth
        zcr_thresh = 16'd4;
        rready = 1'b0;
        framelen = 16'd16;
        start = 1'b1;
        step();
        start = 1'b0;
        held = 0; unstable = 0; ovr = 0; first_r = '0;
        for (int i = 0; i < 80; i++) begin
            v = 1'b1;
            x = 16'sd100;
            step();
            if (rvalid) begin
                if (held == 0) begin
                    held    = 1;
                    first_r = rout;
                end else if (rout !== first_r || ridx !== 4'd0) begin
                    unstable++;
                end
            end
            if (overrun) ovr++;
        end
        v = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        if (overrun) ovr++;
        chk("bp held", held, 1);
        chk("bp lag0 held", first_r, 625);
        chk("bp stable", unstable, 0);
        chk("bp overruns", ovr, 4);
        collect(600);
        chk("bp done", timed_out, 0);
        chk("bp count", n_emit, 11);
        chk("bp order", seq_ok, 1);
        chk("bp lag10", got[10], 234);

        // Reset during MAC; voiced=1 and rout=234 before it
        send_frame(16'd16, 16, 1'b0, 100, 1'b1);
        repeat (4) step();
        rst = 1'b1;
        step();
        chk_zero("rst mac");
        rst = 1'b0;
        cnt_v = 0;
        repeat (400) begin
            step();
            if (rvalid || frame_done || overrun) cnt_v++;
        end
        chk("rst mac quiet", cnt_v, 0);

        // Reset during EMIT
        rready = 1'b0;
        send_frame(16'd16, 16, 1'b0, 100, 1'b1);
        t = 0;
        while (!rvalid && t < 200) begin
            step();
            t++;
        end
        chk("emit reached", rvalid, 1);
        chk("emit lag0", rout, 625);
        rst = 1'b1;
        step();
        chk_zero("rst emit");
        rst = 1'b0;
        rready = 1'b1;
        cnt_v = 0;
        repeat (300) begin
            step();
            if (rvalid || frame_done) cnt_v++;
        end
        chk("rst emit quiet", cnt_v, 0);
        send_frame(16'd16, 16, 1'b0, 100, 1'b1);
        collect(400);
        chk("fresh count", n_emit, 11);
        chk("fresh lag0", got[0], 625);

        // stop after 7 of 16 samples
        send_frame(16'd16, 7, 1'b0, 100, 1'b1);
        cnt_v = 0; cnt_fd = 0; cnt_ov = 0;
        repeat (300) begin
            step();
            if (rvalid)     cnt_v++;
            if (frame_done) cnt_fd++;
            if (overrun)    cnt_ov++;
        end
        chk("partial rvalid", cnt_v, 0);
        chk("partial frame_done", cnt_fd, 0);
        chk("partial overrun", cnt_ov, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lpc_analyzer.md
LPC_ANALYZER -- requirements
Module: lpc_analyzer

Interface
REQ-001 Parameter ORDER, default 10: highest autocorrelation lag computed (lags 0..ORDER).
REQ-002 Parameter MAXN, default 256: maximum frame length in samples.
REQ-003 Parameter ACCW, default 40: accumulator width in bits, signed.
REQ-004 Parameter SHIFT, default 8: arithmetic right shift applied to each accumulator before output saturation.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  reset, synchronous to clk, active-high.
REQ-007 start  in  1  one-cycle pulse that begins frame capture.
REQ-008 stop  in  1  one-cycle pulse that ends capture.
REQ-009 v  in  1  input sample valid.
REQ-010 x  in  16  signed input speech sample.
REQ-011 framelen  in  16  samples per frame, latched on start.
REQ-012 zcr_thresh  in  16  zero-crossing threshold for the voicing decision.
REQ-013 energy_thresh  in  32  signed R0 threshold for the voicing decision.
REQ-014 rout  out  32  signed, shifted and saturated autocorrelation value.
REQ-015 ridx  out  4  lag index of rout.
REQ-016 rvalid  out  1  rout and ridx are valid.
REQ-017 rready  in  1  downstream accepts rout.
REQ-018 voiced  out  1  voicing decision for the last completed frame.
REQ-019 zcr  out  16  zero-crossing count for the last completed frame.
REQ-020 frame_done  out  1  one-cycle pulse marking voiced/zcr update.
REQ-021 overrun  out  1  one-cycle pulse marking a dropped frame.

Function
REQ-022 The capture FSM SHALL have states IDLE and RUN: IDLE->RUN on start; RUN->IDLE on stop; start in RUN SHALL be ignored.
REQ-023 On start, N SHALL latch framelen clamped to ORDER+1..MAXN.
REQ-024 In RUN, each cycle with v=1 SHALL write x to the active half of a two-bank sample buffer of MAXN entries per bank.
REQ-025 After the Nth sample, the bank SHALL be handed to the compute FSM and capture SHALL continue into the other bank with no lost sample.
REQ-026 If the compute FSM still holds the other bank when a hand-off is required, the new frame SHALL be discarded, overrun SHALL pulse, and capture SHALL restart in the same bank.
REQ-027 On stop, a partial frame SHALL be discarded; a frame already handed off SHALL complete.
REQ-028 zcr SHALL count samples n=1..N-1 whose sign bit differs from that of x[n-1] within the same frame, computed during capture.
REQ-029 The compute FSM SHALL have states CIDLE, MAC, EMIT, DONE.
REQ-030 In MAC, for lag k, the FSM SHALL accumulate x[n]*x[n-k] for n=k..N-1 at one product per cycle, with a full-precision 32-bit product and ACCW-bit accumulation.
REQ-031 Lag k SHALL enter EMIT 2 cycles after its last product is issued.
REQ-032 In EMIT, rout SHALL equal sat32(acc >>> SHIFT), ridx=k and rvalid=1, held stable until rready=1.
REQ-033 On acceptance, k=ORDER SHALL go to DONE; otherwise MAC SHALL start for k+1.
REQ-034 In DONE, for one cycle: voiced=(zcr<zcr_thresh)&&(R0out>=energy_thresh), frame_done=1, the bank is released, and the FSM goes to CIDLE.
REQ-035 voiced and zcr SHALL hold their values until the next frame_done.
REQ-036 Saturation SHALL clamp to 0x7FFFFFFF and 0x80000000.

Reset
REQ-037 On rst, the FSMs SHALL go to IDLE/CIDLE, both banks SHALL be free, and all counters SHALL clear.
REQ-038 On rst, rout, ridx, rvalid, voiced, zcr, frame_done and overrun SHALL all be 0 on the next cycle, including mid-MAC and mid-EMIT.
REQ-039 Buffer contents SHALL NOT require reset.

Structure
REQ-040 A shared package SHALL hold ORDER, MAXN, ACCW and SHIFT defaults, the capture and compute state encodings, and the sat32 function.
REQ-041 A single sub-module lpc_mac SHALL contain the multiplier, the 2-stage pipeline and the accumulator with clear/enable.

Verification
REQ-042 DC frame: N=16, x=100, SHIFT=8 -> rout lag0=625, lag1=585, lag10=234; zcr=0; voiced=1 with zcr_thresh=4, energy_thresh=100.
REQ-043 Alternating frame: N=32, x=+1000/-1000 -> lag0=125000, lag1=-121094; zcr=31; voiced=0 with zcr_thresh=10.
REQ-044 Saturation: N=256, x=32767, SHIFT=0 -> lag0=0x7FFFFFFF.
REQ-045 Backpressure: rready=0 throughout, v=1 continuously, N=16 -> rvalid held with lag0 stable; one overrun pulse per dropped frame; after rready=1, lags 0..10 appear exactly once, in order.
REQ-046 Reset during MAC and during EMIT -> all outputs 0 next cycle; no rvalid until a fresh start and a full frame.
REQ-047 stop after 7 of 16 samples -> no rvalid, frame_done or overrun.
